// File: rtl/wptr_full_ctrl.sv
// Write-side pointer and status logic for an asynchronous FIFO: Gray write pointer,
// full/almost-full/level derived from the synchronized read pointer, sticky overflow.
module wptr_full_ctrl #(
    parameter int ADDR_WIDTH   = 4,
    parameter int AFULL_THRESH = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  winc,
    input  logic [ADDR_WIDTH:0]   wq2_rptr,
    input  logic                  clr_ovf,
    output logic [ADDR_WIDTH:0]   wptr,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic                  wen,
    output logic                  wfull,
    output logic                  walmost_full,
    output logic [ADDR_WIDTH:0]   wlevel,
    output logic                  woverflow
);

    localparam int PW = ADDR_WIDTH + 1;

    logic [PW-1:0] r_wbin;
    logic [PW-1:0] r_wptr;
    logic          r_wfull;
    logic          r_walmost_full;
    logic [PW-1:0] r_wlevel;
    logic          r_woverflow;

    logic          w_inc;
    logic [PW-1:0] w_wbin_next;
    logic [PW-1:0] w_wgray_next;
    logic [PW-1:0] w_rbin;
    logic [PW-1:0] w_level_next;
    logic          w_full_next;

    assign w_inc        = winc & ~r_wfull;
    assign w_wbin_next  = r_wbin + {{(PW-1){1'b0}}, w_inc};
    assign w_wgray_next = (w_wbin_next >> 1) ^ w_wbin_next;

    // Gray to binary: bit i is the XOR of all bits at or above i.
    always_comb begin
        w_rbin = '0;
        for (int unsigned i = 0; i < PW; i++) begin
            w_rbin[i] = ^(wq2_rptr >> i);
        end
    end

    assign w_level_next = w_wbin_next - w_rbin;
    // Full when the next write pointer is exactly one lap ahead of the read pointer.
    assign w_full_next  = (w_wgray_next == {~wq2_rptr[PW-1:PW-2], wq2_rptr[PW-3:0]});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wbin         <= '0;
            r_wptr         <= '0;
            r_wfull        <= 1'b0;
            r_walmost_full <= 1'b0;
            r_wlevel       <= '0;
            r_woverflow    <= 1'b0;
        end else begin
            r_wbin         <= w_wbin_next;
            r_wptr         <= w_wgray_next;
            r_wfull        <= w_full_next;
            r_walmost_full <= int'(w_level_next) >= AFULL_THRESH;
            r_wlevel       <= w_level_next;
            if (winc && r_wfull) begin
                r_woverflow <= 1'b1;
            end else if (clr_ovf) begin
                r_woverflow <= 1'b0;
            end
        end
    end

    assign wptr         = r_wptr;
    assign waddr        = r_wbin[ADDR_WIDTH-1:0];
    assign wen          = w_inc & ~rst;
    assign wfull        = r_wfull;
    assign walmost_full = r_walmost_full;
    assign wlevel       = r_wlevel;
    assign woverflow    = r_woverflow;

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// Bench for wptr_full_ctrl: directed scenarios plus random writes/reads against
// an occupancy-count reference model.
module tb_wptr_full_ctrl;

    logic       clk;
    logic       rst;
    logic       winc;
    logic [4:0] wq2_rptr;
    logic       clr_ovf;
    logic [4:0] wptr;
    logic [3:0] waddr;
    logic       wen;
    logic       wfull;
    logic       walmost_full;
    logic [4:0] wlevel;
    logic       woverflow;

    int n_assert = 0;
    int n_fail   = 0;

    // reference model: write count, read count, derived occupancy
    logic [4:0] m_wr;
    logic [4:0] m_rd;
    logic [4:0] m_lvl;
    logic       m_full;
    logic       m_afull;
    logic       m_ovf;

    wptr_full_ctrl #(.ADDR_WIDTH(4), .AFULL_THRESH(14)) dut (
        .clk          (clk),
        .rst          (rst),
        .winc         (winc),
        .wq2_rptr     (wq2_rptr),
        .clr_ovf      (clr_ovf),
        .wptr         (wptr),
        .waddr        (waddr),
        .wen          (wen),
        .wfull        (wfull),
        .walmost_full (walmost_full),
        .wlevel       (wlevel),
        .woverflow    (woverflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] gray(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_wr = '0; m_rd = '0; m_lvl = '0;
        m_full = 1'b0; m_afull = 1'b0; m_ovf = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_wptr"}, 32'(wptr), 32'd0);
        chk({tag, "_waddr"}, 32'(waddr), 32'd0);
        chk({tag, "_wen"}, 32'(wen), 32'd0);
        chk({tag, "_wfull"}, 32'(wfull), 32'd0);
        chk({tag, "_afull"}, 32'(walmost_full), 32'd0);
        chk({tag, "_wlevel"}, 32'(wlevel), 32'd0);
        chk({tag, "_ovf"}, 32'(woverflow), 32'd0);
    endtask

    // One clock: drive, check wen before the edge, advance model, check after edge.
    task automatic step(input logic w, input logic c);
        logic [4:0] prev;
        winc     = w;
        clr_ovf  = c;
        wq2_rptr = gray(m_rd);
        #1;
        chk("wen", 32'(wen), 32'(w & ~m_full));
        prev = wptr;
        @(posedge clk);
        if (w && m_full) m_ovf = 1'b1;
        else if (c)      m_ovf = 1'b0;
        if (w && !m_full) m_wr = m_wr + 5'd1;
        m_lvl   = m_wr - m_rd;
        m_full  = (m_lvl == 5'd16);
        m_afull = (m_lvl >= 5'd14);
        #1;
        chk("wptr", 32'(wptr), 32'(gray(m_wr)));
        chk("waddr", 32'(waddr), 32'(m_wr[3:0]));
        chk("wfull", 32'(wfull), 32'(m_full));
        chk("walmost_full", 32'(walmost_full), 32'(m_afull));
        chk("wlevel", 32'(wlevel), 32'(m_lvl));
        chk("woverflow", 32'(woverflow), 32'(m_ovf));
        chk("wptr_onebit", 32'($countones(wptr ^ prev) <= 1), 32'd1);
    endtask

    initial begin
        model_reset();
        rst = 1'b1; winc = 1'b1; clr_ovf = 1'b0; wq2_rptr = '0;
        #2;
        chk_zero("reset");
        #10 rst = 1'b0;

        // fill from empty
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b0);
            if (i == 13) chk("afull_at_14", 32'(walmost_full), 32'd1);
        end
        chk("full_wptr", 32'(wptr), 32'h18);
        chk("full_level", 32'(wlevel), 32'd16);

        // write while full -> sticky overflow
        step(1'b1, 1'b0);
        chk("ovf_wptr_hold", 32'(wptr), 32'h18);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        chk("ovf_sticky", 32'(woverflow), 32'd1);
        step(1'b0, 1'b1);
        chk("ovf_cleared", 32'(woverflow), 32'd0);

        // reader advances by one
        m_rd = 5'd1;
        step(1'b0, 1'b0);
        chk("drain_level", 32'(wlevel), 32'd15);
        step(1'b1, 1'b0);
        chk("refill_wptr", 32'(wptr), 32'h19);

        // set beats clear on the same edge
        step(1'b1, 1'b1);
        chk("set_wins", 32'(woverflow), 32'd1);
        step(1'b0, 1'b1);

        // pointer wrap with tracking reader
        for (int i = 0; i < 20; i++) begin
            m_rd = m_wr - 5'd1;
            step(1'b1, 1'b0);
        end
        chk("wrap_seen", 32'(m_wr < 5'd17), 32'd1);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            if (($urandom % 2) == 1 && (m_wr - m_rd) != 5'd0) m_rd = m_rd + 5'd1;
            step(($urandom % 10) < 7, ($urandom % 20) == 0);
        end

        // reset mid-burst, between edges
        winc = 1'b1;
        #3 rst = 1'b1;
        #1;
        chk_zero("midrst");
        model_reset();
        wq2_rptr = '0;
        #2 rst = 1'b0;
        #1;
        chk("post_rst_waddr", 32'(waddr), 32'd0);
        chk("post_rst_wen", 32'(wen), 32'd1);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/wptr_full_ctrl.md
WPTR_FULL_CTRL -- requirements
Module: wptr_full_ctrl

Interface
REQ-001 SHALL provide parameter ADDR_WIDTH, default 4, meaning FIFO address width (depth = 2**ADDR_WIDTH, pointer width PW = ADDR_WIDTH+1).
REQ-002 SHALL provide parameter AFULL_THRESH, default 14, meaning fill level at or above which walmost_full asserts.
REQ-003 SHALL provide port clk  input  1  write-domain clock.
REQ-004 SHALL provide port rst  input  1  reset; one clock; reset is asynchronous and active-high.
REQ-005 SHALL provide port winc  input  1  write request.
REQ-006 SHALL provide port wq2_rptr  input  PW  Gray read pointer, already two-stage synchronized into clk domain.
REQ-007 SHALL provide port clr_ovf  input  1  clears sticky overflow flag.
REQ-008 SHALL provide port wptr  output  PW  registered Gray write pointer, sent to read-domain synchronizer.
REQ-009 SHALL provide port waddr  output  ADDR_WIDTH  registered binary write address to FIFO memory.
REQ-010 SHALL provide port wen  output  1  memory write strobe.
REQ-011 SHALL provide port wfull  output  1  registered full flag.
REQ-012 SHALL provide port walmost_full  output  1  registered almost-full flag.
REQ-013 SHALL provide port wlevel  output  PW  registered fill level, write-domain view.
REQ-014 SHALL provide port woverflow  output  1  sticky overflow flag.

Function
REQ-015 SHALL hold internal binary pointer wbin (PW bits); wbin_next = wbin + (winc & ~wfull), modulo 2**PW.
REQ-016 SHALL compute wgray_next = (wbin_next >> 1) ^ wbin_next; wptr <= wgray_next every clk edge.
REQ-017 SHALL drive waddr = wbin[ADDR_WIDTH-1:0] (from register, no combinational path from winc).
REQ-018 SHALL drive wen = winc & ~wfull combinationally; write to memory occurs at waddr on the same edge wbin advances.
REQ-019 SHALL register wfull <= (wgray_next == {~wq2_rptr[PW-1:PW-2], wq2_rptr[PW-3:0]}); full asserts on the same edge as the filling write.
REQ-020 SHALL convert wq2_rptr Gray->binary (rbin_s) combinationally, bit i = XOR of bits PW-1..i.
REQ-021 SHALL register wlevel <= (wbin_next - rbin_s) modulo 2**PW; range 0..2**ADDR_WIDTH.
REQ-022 SHALL register walmost_full <= (wbin_next - rbin_s) >= AFULL_THRESH.
REQ-023 SHALL set woverflow on any edge where winc & wfull; clear it on clr_ovf; set wins when both occur on the same edge.
REQ-024 SHALL ignore writes while wfull=1: wbin, wptr, waddr unchanged, wen=0.
REQ-025 SHALL wrap wbin from 2**PW-1 to 0; wptr then changes exactly one bit (Gray property holds across wrap).
REQ-026 SHALL change at most one bit of wptr per clk edge under all stimulus.
REQ-027 SHALL deassert wfull only after wq2_rptr advances (full is pessimistic by synchronizer latency); no combinational path from wq2_rptr to any output except via registers.

Reset
REQ-028 SHALL, while rst=1, immediately (no clock) force wbin=0, wptr=0, waddr=0, wfull=0, walmost_full=0, wlevel=0, woverflow=0.
REQ-029 SHALL force wen=0 while rst=1.
REQ-030 SHALL resume from pointer 0 on first clk edge after rst deasserts; a reset mid-burst discards in-flight pointer state.

Verification (ADDR_WIDTH=4, AFULL_THRESH=14)
REQ-031 Reset, wq2_rptr=0, 16 consecutive winc -> wptr sequence 00000,00001,00011,00010,...; walmost_full=1 on edge of 14th write; wfull=1, wlevel=16, wptr=11000 on edge of 16th write.
REQ-032 From full, one more winc -> wen=0, wptr stays 11000, woverflow=1 and remains 1 until clr_ovf pulsed.
REQ-033 From full, wq2_rptr=00001 (rbin 1) -> next edge wfull=0, wlevel=15, walmost_full=1; a following winc -> wfull=1 again, wptr=11001.
REQ-034 Pointer wrap: drive wbin to 31 via writes with reader tracking (wq2_rptr kept level 0-2), one more write -> wptr 10000->00000, waddr 15->0, no false wfull.
REQ-035 clr_ovf and winc&wfull on same edge -> woverflow remains 1.
REQ-036 rst asserted mid-burst between clk edges -> all outputs 0 immediately; after release, first write uses waddr=0.
